hwpe_copy_ctrl: RTL and testbench



---
 rtl/hwpe_copy_package.sv | 30 +++
 rtl/hwpe_stream_package.sv | 41 ++++
 rtl/hwpe_copy_job_queue.sv | 60 ++++++
 rtl/hwpe_copy_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_hwpe_copy_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hwpe_copy_package.sv
// ============================================================================
//  Module      : hwpe_copy_package
//  Description : Job descriptor, FSM encoding and constants of the copy
//                controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hwpe_copy_package;

    localparam logic [15:0] COPY_LINE_STRIDE = 16'd4;

    // len is kept at full 32 bits so the queue is independent of LEN_WIDTH
    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] len;
    } copy_job_t;

    typedef enum logic [2:0] {
        COPY_IDLE  = 3'd0,
        COPY_ARM   = 3'd1,
        COPY_RUN   = 3'd2,
        COPY_DRAIN = 3'd3,
        COPY_ABORT = 3'd4
    } copy_state_t;

endpackage

`default_nettype wire

// File: rtl/hwpe_stream_package.sv
// ============================================================================
//  Module      : hwpe_stream_package
//  Description : Stream source/sink programming and status types shared by
//                the HWPE stream datapath blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hwpe_stream_package;

    typedef struct packed {
        logic [31:0] base_addr;
        logic [31:0] trans_size;
        logic [15:0] line_stride;
        logic [15:0] line_length;
        logic [15:0] feat_stride;
        logic [15:0] feat_length;
        logic [15:0] feat_roll;
        logic        loop_outer;
        logic        realign_type;
        logic [15:0] step;
    } ctrl_addressgen_t;

    typedef struct packed {
        logic             req_start;
        ctrl_addressgen_t addressgen_ctrl;
    } ctrl_sourcesink_t;

    typedef struct packed {
        logic ready_start;
        logic done;
    } flags_sourcesink_t;

    typedef struct packed {
        logic empty;
        logic full;
    } flags_fifo_t;

endpackage

`default_nettype wire

// File: rtl/hwpe_copy_job_queue.sv
// ============================================================================
//  Module      : hwpe_copy_job_queue
//  Description : Two-entry FIFO of copy jobs with synchronous clear.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hwpe_copy_job_queue
    import hwpe_copy_package::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_i,
    input  logic       push_i,
    input  copy_job_t  push_data_i,
    input  logic       pop_i,
    output copy_job_t  head_o,
    output logic       full_o,
    output logic       empty_o,
    output logic [1:0] count_o
);

    copy_job_t  r_mem [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;

    // A push into a full queue is legal only together with a pop: the slot
    // being written is the one being read out this cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (clear_i) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (push_i) begin
                r_mem[r_wr_ptr] <= push_data_i;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (pop_i) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    assign head_o  = r_mem[r_rd_ptr];
    assign full_o  = (r_count == 2'd2);
    assign empty_o = (r_count == 2'd0);
    assign count_o = r_count;

endmodule

`default_nettype wire

// File: rtl/hwpe_copy_ctrl.sv
// ============================================================================
//  Module      : hwpe_copy_ctrl
//  Description : Copy job controller: queues jobs, starts source and sink,
//                waits for completion and store drain, aborts hung jobs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hwpe_copy_ctrl
    import hwpe_stream_package::*;
    import hwpe_copy_package::*;
#(
    parameter int unsigned LEN_WIDTH   = 16,
    parameter int unsigned WDOG_CYCLES = 4096,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 job_valid_i,
    output logic                 job_ready_o,
    input  logic [31:0]          job_src_addr_i,
    input  logic [31:0]          job_dst_addr_i,
    input  logic [LEN_WIDTH-1:0] job_len_i,
    output ctrl_sourcesink_t     source_ctrl_o,
    input  flags_sourcesink_t    source_flags_i,
    output ctrl_sourcesink_t     sink_ctrl_o,
    input  flags_sourcesink_t    sink_flags_i,
    input  flags_fifo_t          store_fifo_flags_i,
    output logic                 dp_clear_o,
    output logic                 busy_o,
    output logic                 evt_done_o,
    output logic                 evt_err_o,
    output logic [CNT_WIDTH-1:0] job_cnt_o
);

    localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES);

    copy_state_t          r_state;
    copy_job_t            r_cur;
    logic                 r_src_done;
    logic                 r_snk_done;
    logic [WDOG_W-1:0]    r_wdog;
    logic                 r_req_start;
    logic                 r_evt_done;
    logic                 r_evt_err;
    logic                 r_dp_clear;
    logic                 r_busy;
    logic [CNT_WIDTH-1:0] r_job_cnt;

    copy_job_t  w_head;
    copy_job_t  w_push_job;
    copy_job_t  w_ctrl_job;
    logic       w_ctrl_en;
    logic       w_full;
    logic       w_empty;
    logic [1:0] w_count;
    logic [1:0] w_count_nxt;
    logic       w_push;
    logic       w_pop;
    logic       w_zero_len;
    logic       w_start;
    logic       w_src_done;
    logic       w_snk_done;
    logic       w_run_done;
    logic       w_drain_done;
    logic       w_wdog_hit;
    logic       w_fsm_active_nxt;
    logic       w_unused;

    assign w_unused   = store_fifo_flags_i.full;
    assign w_push_job = '{src: job_src_addr_i, dst: job_dst_addr_i, len: 32'(job_len_i)};

    assign job_ready_o  = ~w_full;
    assign w_push       = job_valid_i & ~w_full & ~clear_i;
    assign w_zero_len   = ~w_empty & (w_head.len == 32'd0);
    assign w_start      = (r_state == COPY_ARM) & source_flags_i.ready_start & sink_flags_i.ready_start;
    assign w_src_done   = r_src_done | source_flags_i.done;
    assign w_snk_done   = r_snk_done | sink_flags_i.done;
    assign w_run_done   = (r_state == COPY_RUN) & w_src_done & w_snk_done;
    assign w_drain_done = (r_state == COPY_DRAIN) & store_fifo_flags_i.empty;
    assign w_wdog_hit   = ((r_state == COPY_RUN) | (r_state == COPY_DRAIN)) &
                          (r_wdog == WDOG_W'(WDOG_CYCLES - 1));
    assign w_pop        = ~clear_i & (((r_state == COPY_IDLE) & w_zero_len) | w_start);
    assign w_count_nxt  = clear_i ? 2'd0 : (w_count + {1'b0, w_push} - {1'b0, w_pop});

    hwpe_copy_job_queue u_job_queue (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .push_i      (w_push),
        .push_data_i (w_push_job),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .full_o      (w_full),
        .empty_o     (w_empty),
        .count_o     (w_count)
    );

    // Next-cycle FSM activity, so that busy_o can be a plain register
    always_comb begin
        w_fsm_active_nxt = 1'b0;
        case (r_state)
            COPY_IDLE:  w_fsm_active_nxt = ~w_empty & ~w_zero_len;
            COPY_ARM:   w_fsm_active_nxt = 1'b1;
            COPY_RUN:   w_fsm_active_nxt = 1'b1;
            COPY_DRAIN: w_fsm_active_nxt = ~w_drain_done;
            default:    w_fsm_active_nxt = 1'b0;
        endcase
        if (clear_i) begin
            w_fsm_active_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= COPY_IDLE;
            r_cur       <= '0;
            r_src_done  <= 1'b0;
            r_snk_done  <= 1'b0;
            r_wdog      <= '0;
            r_req_start <= 1'b0;
            r_evt_done  <= 1'b0;
            r_evt_err   <= 1'b0;
            r_dp_clear  <= 1'b0;
            r_busy      <= 1'b0;
            r_job_cnt   <= '0;
        end else begin
            r_req_start <= 1'b0;
            r_evt_done  <= 1'b0;
            r_evt_err   <= 1'b0;
            r_dp_clear  <= 1'b0;
            r_busy      <= w_fsm_active_nxt | (w_count_nxt != 2'd0);
            if (clear_i) begin
                r_state    <= COPY_IDLE;
                r_cur      <= '0;
                r_src_done <= 1'b0;
                r_snk_done <= 1'b0;
                r_wdog     <= '0;
                r_dp_clear <= 1'b1;
            end else begin
                case (r_state)
                    COPY_IDLE: begin
                        if (w_zero_len) begin
                            r_evt_err <= 1'b1;
                        end else if (!w_empty) begin
                            r_state <= COPY_ARM;
                        end
                    end
                    COPY_ARM: begin
                        if (w_start) begin
                            r_req_start <= 1'b1;
                            r_cur       <= w_head;
                            r_src_done  <= 1'b0;
                            r_snk_done  <= 1'b0;
                            r_wdog      <= '0;
                            r_state     <= COPY_RUN;
                        end
                    end
                    COPY_RUN: begin
                        r_src_done <= w_src_done;
                        r_snk_done <= w_snk_done;
                        r_wdog     <= r_wdog + 1'b1;
                        if (w_run_done) begin
                            r_state <= COPY_DRAIN;
                        end else if (w_wdog_hit) begin
                            r_state    <= COPY_ABORT;
                            r_dp_clear <= 1'b1;
                            r_evt_err  <= 1'b1;
                        end
                    end
                    COPY_DRAIN: begin
                        r_wdog <= r_wdog + 1'b1;
                        if (w_drain_done) begin
                            r_evt_done <= 1'b1;
                            r_job_cnt  <= r_job_cnt + 1'b1;
                            r_state    <= COPY_IDLE;
                        end else if (w_wdog_hit) begin
                            r_state    <= COPY_ABORT;
                            r_dp_clear <= 1'b1;
                            r_evt_err  <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= COPY_IDLE;
                    end
                endcase
            end
        end
    end

    // Head job is shown while arming; the latched copy afterwards
    always_comb begin
        w_ctrl_job = '0;
        w_ctrl_en  = 1'b0;
        case (r_state)
            COPY_ARM: begin
                w_ctrl_job = w_head;
                w_ctrl_en  = 1'b1;
            end
            COPY_RUN, COPY_DRAIN: begin
                w_ctrl_job = r_cur;
                w_ctrl_en  = 1'b1;
            end
            default: begin
                w_ctrl_job = '0;
                w_ctrl_en  = 1'b0;
            end
        endcase
        source_ctrl_o = '0;
        sink_ctrl_o   = '0;
        if (w_ctrl_en) begin
            source_ctrl_o.addressgen_ctrl.base_addr   = w_ctrl_job.src;
            source_ctrl_o.addressgen_ctrl.trans_size  = w_ctrl_job.len;
            source_ctrl_o.addressgen_ctrl.line_length = w_ctrl_job.len[15:0];
            source_ctrl_o.addressgen_ctrl.line_stride = COPY_LINE_STRIDE;
            sink_ctrl_o.addressgen_ctrl.base_addr     = w_ctrl_job.dst;
            sink_ctrl_o.addressgen_ctrl.trans_size    = w_ctrl_job.len;
            sink_ctrl_o.addressgen_ctrl.line_length   = w_ctrl_job.len[15:0];
            sink_ctrl_o.addressgen_ctrl.line_stride   = COPY_LINE_STRIDE;
        end
        source_ctrl_o.req_start = r_req_start;
        sink_ctrl_o.req_start   = r_req_start;
    end

    assign dp_clear_o = r_dp_clear;
    assign busy_o     = r_busy;
    assign evt_done_o = r_evt_done;
    assign evt_err_o  = r_evt_err;
    assign job_cnt_o  = r_job_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hwpe_copy_ctrl.sv
// ============================================================================
//  Module      : tb_hwpe_copy_ctrl
//  Description : Scoreboard bench for the copy job controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hwpe_copy_ctrl;
    import hwpe_stream_package::*;
    import hwpe_copy_package::*;

    localparam int WDOG = 16;

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] len;
        int          sd;
        int          kd;
    } tb_job_t;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic              clear_i = 1'b0;
    logic              job_valid_i = 1'b0;
    logic              job_ready_o;
    logic [31:0]       job_src_addr_i = '0;
    logic [31:0]       job_dst_addr_i = '0;
    logic [15:0]       job_len_i = '0;
    ctrl_sourcesink_t  source_ctrl_o;
    ctrl_sourcesink_t  sink_ctrl_o;
    flags_sourcesink_t source_flags_i;
    flags_sourcesink_t sink_flags_i;
    flags_fifo_t       store_fifo_flags_i;
    logic              dp_clear_o;
    logic              busy_o;
    logic              evt_done_o;
    logic              evt_err_o;
    logic [15:0]       job_cnt_o;

    logic src_ready = 1'b1;
    logic snk_ready = 1'b1;
    logic src_done = 1'b0;
    logic snk_done = 1'b0;
    logic store_empty = 1'b1;

    assign source_flags_i     = '{ready_start: src_ready, done: src_done};
    assign sink_flags_i       = '{ready_start: snk_ready, done: snk_done};
    assign store_fifo_flags_i = '{empty: store_empty, full: 1'b0};

    tb_job_t exp_q[$];
    tb_job_t cur;
    bit      cur_active = 1'b0;
    bit      pulse_watch = 1'b0;
    int      cur_req_cyc = 0;
    int      last_req_cyc = 0;
    int      src_cnt = 0;
    int      snk_cnt = 0;
    int      exp_cnt = 0;
    int      cyc = 0;
    int      n_checks = 0;
    int      n_fail = 0;

    hwpe_copy_ctrl #(
        .LEN_WIDTH   (16),
        .WDOG_CYCLES (WDOG),
        .CNT_WIDTH   (16)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_ni),
        .clear_i            (clear_i),
        .job_valid_i        (job_valid_i),
        .job_ready_o        (job_ready_o),
        .job_src_addr_i     (job_src_addr_i),
        .job_dst_addr_i     (job_dst_addr_i),
        .job_len_i          (job_len_i),
        .source_ctrl_o      (source_ctrl_o),
        .source_flags_i     (source_flags_i),
        .sink_ctrl_o        (sink_ctrl_o),
        .sink_flags_i       (sink_flags_i),
        .store_fifo_flags_i (store_fifo_flags_i),
        .dp_clear_o         (dp_clear_o),
        .busy_o             (busy_o),
        .evt_done_o         (evt_done_o),
        .evt_err_o          (evt_err_o),
        .job_cnt_o          (job_cnt_o)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Source/sink model and scoreboard, evaluated on the falling edge
    always @(negedge clk) begin
        if (!rst_ni) begin
            src_done = 1'b0;
            snk_done = 1'b0;
        end else begin
            src_done = 1'b0;
            snk_done = 1'b0;
            if (src_cnt > 0) begin
                src_cnt--;
                if (src_cnt == 0) src_done = 1'b1;
            end
            if (snk_cnt > 0) begin
                snk_cnt--;
                if (snk_cnt == 0) snk_done = 1'b1;
            end
            if (pulse_watch) begin
                check_val("err_pulse_width", {evt_err_o, dp_clear_o}, 2'b00);
                pulse_watch = 1'b0;
            end
            if (source_ctrl_o.req_start || sink_ctrl_o.req_start) begin
                check_val("req_sync", {source_ctrl_o.req_start, sink_ctrl_o.req_start}, 2'b11);
                if (exp_q.size() == 0 || cur_active) begin
                    check_val("req_unexpected", 1, 0);
                end else begin
                    cur = exp_q.pop_front();
                    check_val("zero_no_start", cur.len == 16'd0, 0);
                    check_val("src_base", source_ctrl_o.addressgen_ctrl.base_addr, cur.src);
                    check_val("snk_base", sink_ctrl_o.addressgen_ctrl.base_addr, cur.dst);
                    check_val("src_size", source_ctrl_o.addressgen_ctrl.trans_size, cur.len);
                    check_val("snk_size", sink_ctrl_o.addressgen_ctrl.trans_size, cur.len);
                    check_val("src_linelen", source_ctrl_o.addressgen_ctrl.line_length, cur.len);
                    check_val("snk_stride", sink_ctrl_o.addressgen_ctrl.line_stride, 4);
                    check_val("src_stride", source_ctrl_o.addressgen_ctrl.line_stride, 4);
                    check_val("src_other_zero", |{source_ctrl_o.addressgen_ctrl.feat_stride,
                        source_ctrl_o.addressgen_ctrl.feat_length, source_ctrl_o.addressgen_ctrl.feat_roll,
                        source_ctrl_o.addressgen_ctrl.loop_outer, source_ctrl_o.addressgen_ctrl.realign_type,
                        source_ctrl_o.addressgen_ctrl.step}, 0);
                    cur_active   = 1'b1;
                    cur_req_cyc  = cyc;
                    last_req_cyc = cyc;
                    src_cnt      = cur.sd;
                    snk_cnt      = cur.kd;
                end
            end
            if (evt_done_o) begin
                if (!cur_active) begin
                    check_val("done_unexpected", 1, 0);
                end else begin
                    check_val("done_not_hung", (cur.sd == 0) || (cur.kd == 0), 0);
                    check_val("done_latency", cyc - cur_req_cyc,
                              ((cur.sd > cur.kd) ? cur.sd : cur.kd) + 2);
                    exp_cnt++;
                    check_val("job_cnt", job_cnt_o, exp_cnt);
                    cur_active = 1'b0;
                end
            end
            if (evt_err_o) begin
                if (dp_clear_o) begin
                    if (!cur_active) begin
                        check_val("abort_unexpected", 1, 0);
                    end else begin
                        check_val("abort_hung_job", (cur.sd == 0) || (cur.kd == 0), 1);
                        check_val("abort_latency", cyc - cur_req_cyc, WDOG);
                        cur_active = 1'b0;
                        src_cnt    = 0;
                        snk_cnt    = 0;
                    end
                end else begin
                    if (exp_q.size() == 0) begin
                        check_val("err_unexpected", 1, 0);
                    end else begin
                        tb_job_t z;
                        z = exp_q.pop_front();
                        check_val("err_zero_len", z.len, 0);
                    end
                end
                pulse_watch = 1'b1;
            end
        end
    end

    task automatic offer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                         input int sd, input int kd, output int acc, output int waits);
        tb_job_t j;
        j.src = s;
        j.dst = d;
        j.len = l;
        j.sd  = sd;
        j.kd  = kd;
        waits = 0;
        @(negedge clk);
        job_valid_i    = 1'b1;
        job_src_addr_i = s;
        job_dst_addr_i = d;
        job_len_i      = l;
        while (!job_ready_o && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        check_val("offer_accepted", job_ready_o, 1);
        acc = cyc;
        exp_q.push_back(j);
        @(posedge clk);
    endtask

    task automatic drop_valid();
        @(negedge clk);
        job_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy_o || cur_active || exp_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_val("idle_timeout", n >= 300, 0);
    endtask

    task automatic wait_started();
        int n;
        n = 0;
        while (!cur_active && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("start_timeout", cur_active, 1);
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_ready"}, job_ready_o, 1);
        check_val({tag, "_busy"}, busy_o, 0);
        check_val({tag, "_evts"}, {evt_done_o, evt_err_o, dp_clear_o}, 3'b000);
        check_val({tag, "_cnt"}, job_cnt_o, 0);
        check_val({tag, "_src_ctrl"}, |source_ctrl_o, 0);
        check_val({tag, "_snk_ctrl"}, |sink_ctrl_o, 0);
    endtask

    initial begin
        int acc_a, acc_b, acc_c, w_a, w_b, w_c;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("rst");
        rst_ni = 1'b1;

        // Single job and start latency
        offer(32'h1000, 32'h2000, 16'd8, 3, 2, acc_a, w_a);
        drop_valid();
        wait_idle();
        check_val("req_latency", last_req_cyc - acc_a, 3);

        // Sink done well before source done, then simultaneous done
        offer(32'h3000, 32'h4000, 16'd16, 7, 2, acc_a, w_a);
        offer(32'h3100, 32'h4100, 16'd2, 3, 3, acc_b, w_b);
        drop_valid();
        wait_idle();

        // Three jobs back to back: third waits for the first pop
        offer(32'h5000, 32'h6000, 16'd1, 1, 1, acc_a, w_a);
        offer(32'h5100, 32'h6100, 16'd5, 2, 1, acc_b, w_b);
        offer(32'h5200, 32'h6200, 16'd9, 1, 3, acc_c, w_c);
        drop_valid();
        wait_idle();
        check_val("b2b_second_acc", acc_b - acc_a, 1);
        check_val("b2b_second_wait", w_b, 0);
        check_val("b2b_third_acc", acc_c - acc_a, 3);
        check_val("b2b_third_wait", w_c, 1);
        check_val("b2b_cnt", job_cnt_o, 6);

        // Zero-length job is discarded with an error
        offer(32'h7000, 32'h8000, 16'd0, 1, 1, acc_a, w_a);
        offer(32'h7100, 32'h8100, 16'd4, 2, 2, acc_b, w_b);
        drop_valid();
        wait_idle();

        // Source never finishes: watchdog abort, then the next job runs
        offer(32'h9000, 32'hA000, 16'd6, 0, 2, acc_a, w_a);
        offer(32'h9100, 32'hA100, 16'd3, 2, 2, acc_b, w_b);
        drop_valid();
        wait_idle();

        // Soft clear in RUN with one job queued and a concurrent push
        offer(32'hB000, 32'hC000, 16'd6, 0, 0, acc_a, w_a);
        offer(32'hB100, 32'hC100, 16'd3, 2, 2, acc_b, w_b);
        drop_valid();
        wait_started();
        repeat (3) @(negedge clk);
        clear_i        = 1'b1;
        job_valid_i    = 1'b1;
        job_src_addr_i = 32'hDEAD0000;
        job_dst_addr_i = 32'hBEEF0000;
        job_len_i      = 16'd5;
        @(negedge clk);
        clear_i     = 1'b0;
        job_valid_i = 1'b0;
        check_val("clr_dp_clear", dp_clear_o, 1);
        check_val("clr_busy", busy_o, 0);
        check_val("clr_ready", job_ready_o, 1);
        check_val("clr_cnt_kept", job_cnt_o, exp_cnt);
        check_val("clr_no_err", evt_err_o, 0);
        check_val("clr_src_ctrl", |source_ctrl_o, 0);
        exp_q.delete();
        cur_active = 1'b0;
        src_cnt    = 0;
        snk_cnt    = 0;
        @(negedge clk);
        check_val("clr_pulse_end", dp_clear_o, 0);
        check_val("clr_push_dropped", busy_o, 0);
        offer(32'hE000, 32'hF000, 16'd2, 1, 1, acc_a, w_a);
        drop_valid();
        wait_idle();

        // Asynchronous reset while draining
        store_empty = 1'b0;
        offer(32'h1100, 32'h2100, 16'd4, 2, 2, acc_a, w_a);
        drop_valid();
        wait_started();
        repeat (5) @(negedge clk);
        check_val("drain_busy", {busy_o, evt_done_o}, 2'b10);
        #2;
        rst_ni = 1'b0;
        #1;
        exp_q.delete();
        cur_active = 1'b0;
        src_cnt    = 0;
        snk_cnt    = 0;
        exp_cnt    = 0;
        check_reset_values("arst");
        @(negedge clk);
        rst_ni      = 1'b1;
        store_empty = 1'b1;
        offer(32'h1200, 32'h2200, 16'd3, 1, 2, acc_a, w_a);
        drop_valid();
        wait_idle();

        check_val("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule

`default_nettype wire
